// File: rtl/fpu_pkg.sv
// +----------------------------------------------------------------------+
// | fpu_pkg: shared FPU mantissa constants, FSM encoding, width helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

  localparam int MANT_W_SP = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } div_state_t;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// +----------------------------------------------------------------------+
// | fa_cell: single-bit full adder.                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/sub_ripple.sv
// +----------------------------------------------------------------------+
// | sub_ripple: ripple-borrow subtractor a - b as a + ~b + 1 on FA cells. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sub_ripple #(
  parameter int N = 25
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    fa_cell u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

  // Carry out of a + ~b + 1 is set exactly when a >= b.
  assign no_borrow = carry[N];

endmodule

`default_nettype wire

// File: rtl/mant_div_seq.sv
// +----------------------------------------------------------------------+
// | mant_div_seq: iterative radix-2 restoring unsigned mantissa divider. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mant_div_seq
  import fpu_pkg::*;
#(
  parameter int WIDTH = MANT_W_SP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;

  // P[WIDTH] is always zero between iterations, so the shift drops nothing.
  assign shifted = (p_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};

  sub_ripple #(.N(WIDTH + 1)) u_sub (
    .a         (shifted),
    .b         ({1'b0, d_q}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  assign p_next = no_borrow ? diff : shifted;
  assign q_next = {q_q[WIDTH-2:0], no_borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_CALC;
          cnt_d   = '0;
          p_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          zero_d  = (divisor == '0);
        end
      end
      S_CALC: begin
        // A zero divisor spends a single cycle here so done lands one cycle after acceptance.
        if (zero_q) begin
          state_d = S_DONE;
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
        end else begin
          p_d   = p_next;
          q_d   = q_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
            quot_d  = q_next;
            rem_d   = p_next[WIDTH-1:0];
            dbz_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
